rr_arbiter: RTL



---
 rtl/arb_pkg.sv | 14 +
 rtl/masked_pridec.sv | 48 ++++
 rtl/rr_arbiter.sv | 127 ++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin arbiter.
package arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Index width for a vector of the given size, never narrower than one bit.
  function automatic int arb_idw(input int width);
    return (width <= 1) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/masked_pridec.sv
// Rotating-priority search: lowest-index winner among requesters above ptr,
// falling back to the lowest-index requester overall when none are above it.
module masked_pridec
  import arb_pkg::*;
#(
  parameter  int WIDTH = 4,
  localparam int IDW   = arb_idw(WIDTH)
) (
  input  logic [WIDTH-1:0] req,
  input  logic [IDW-1:0]   ptr,
  output logic [WIDTH-1:0] win_oh,
  output logic [IDW-1:0]   win_idx
);

  logic [WIDTH-1:0] masked;
  logic [WIDTH-1:0] m_oh, u_oh;
  logic [IDW-1:0]   m_idx, u_idx;
  logic             m_any, u_any;

  // Mask out ptr and everything below it, then decode both vectors and pick.
  always_comb begin
    masked = '0;
    m_oh   = '0;
    u_oh   = '0;
    m_idx  = '0;
    u_idx  = '0;
    m_any  = 1'b0;
    u_any  = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      masked[i] = req[i] && (i > int'(ptr));
    end
    for (int i = 0; i < WIDTH; i++) begin
      if (!m_any && masked[i]) begin
        m_oh[i] = 1'b1;
        m_idx   = IDW'(i);
        m_any   = 1'b1;
      end
      if (!u_any && req[i]) begin
        u_oh[i] = 1'b1;
        u_idx   = IDW'(i);
        u_any   = 1'b1;
      end
    end
    win_oh  = m_any ? m_oh  : u_oh;
    win_idx = m_any ? m_idx : u_idx;
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with registered one-hot grant.
// Optional grant locking (hold port, bounded by MAX_HOLD) when RR_ARB_LOCK_EN
// is defined; without it every enabled cycle re-arbitrates.
//
// state | meaning
// IDLE  | no grant outstanding, waiting for any request
// GRANT | one requester granted; re-arbitrate or lock each enabled cycle
module rr_arbiter
  import arb_pkg::*;
#(
  parameter  int WIDTH    = 4,
  parameter  int MAX_HOLD = 8,
  localparam int IDW      = arb_idw(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] req,
`ifdef RR_ARB_LOCK_EN
  input  logic             hold,
`endif
  output logic [WIDTH-1:0] gnt,
  output logic             gnt_valid,
  output logic [IDW-1:0]   gnt_id
);

  arb_state_e       state_q, state_d;
  logic [WIDTH-1:0] gnt_q, gnt_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic [IDW-1:0]   gnt_id_q, gnt_id_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [WIDTH-1:0] win_oh;
  logic [IDW-1:0]   win_idx;
  logic             locked;

  masked_pridec #(.WIDTH(WIDTH)) u_pridec (
    .req     (req),
    .ptr     (ptr_q),
    .win_oh  (win_oh),
    .win_idx (win_idx)
  );

`ifdef RR_ARB_LOCK_EN
  localparam int HCW = arb_idw(MAX_HOLD + 1);

  logic [HCW-1:0] hold_cnt_q, hold_cnt_d;

  // Lock while the holder keeps requesting and asserting hold, up to MAX_HOLD cycles.
  assign locked = (state_q == GRANT) && hold && req[gnt_id_q] &&
                  (int'(hold_cnt_q) < MAX_HOLD - 1);

  // Count locked cycles; any non-locked decision in GRANT restarts the count.
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (en && (state_q == GRANT)) begin
      hold_cnt_d = locked ? hold_cnt_q + 1'b1 : '0;
    end
  end

  // Hold counter register; reset discards any lock in progress.
  always_ff @(posedge clk) begin
    if (!rst) hold_cnt_q <= '0;
    else      hold_cnt_q <= hold_cnt_d;
  end
`else
  assign locked = 1'b0;
`endif

  // Next-state and next-grant decision.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    gnt_id_d = gnt_id_q;
    ptr_d   = ptr_q;
    if (en) begin
      case (state_q)
        IDLE: begin
          if (|req) begin
            gnt_d    = win_oh;
            gnt_id_d = win_idx;
            ptr_d    = win_idx;
            state_d  = GRANT;
          end
        end
        GRANT: begin
          if (locked) begin
            gnt_d = gnt_q;
          end else if (|req) begin
            gnt_d    = win_oh;
            gnt_id_d = win_idx;
            ptr_d    = win_idx;
          end else begin
            gnt_d   = '0;
            state_d = IDLE;
          end
        end
        default: begin
          gnt_d   = '0;
          state_d = IDLE;
        end
      endcase
    end
    gnt_valid_d = |gnt_d;
  end

  // State and output registers; reset leaves ptr on the last index so 0 wins first.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      gnt_id_q    <= '0;
      ptr_q       <= IDW'(WIDTH - 1);
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_id_q    <= gnt_id_d;
      ptr_q       <= ptr_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = gnt_valid_q;
  assign gnt_id    = gnt_id_q;

endmodule
